byte_word_packer: RTL and testbench

Downstream consumer of the ping-pong buffer's 8-bit output stream. Packs consecutive valid bytes into 32-bit little-endian words, with per-lane keep bits. Presents the words on a ready/valid output slot toward the wide datapath. Supports an explicit flush for partial words and flags bytes dropped under backpressure, since the ping-pong stage cannot stall.

---
 rtl/byte_word_packer_pkg.sv | 19 +
 rtl/byte_word_packer_word_out_slot.sv | 47 ++++
 rtl/byte_word_packer.sv | 136 +++++++++++++
 tb/tb_byte_word_packer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/byte_word_packer_pkg.sv
// Shared constants and types for the byte-to-word packer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default byte width and lane count, derived keep/index/word widths,
// and the lane-index, keep and word types used by the packer and its bench.
package byte_word_packer_pkg;

    localparam int BWP_DATA_W = 8;
    localparam int BWP_LANES  = 4;
    localparam int BWP_KEEP_W = BWP_LANES;
    localparam int BWP_WORD_W = BWP_DATA_W * BWP_LANES;
    localparam int BWP_LANE_W = (BWP_LANES > 1) ? $clog2(BWP_LANES) : 1;

    typedef logic [BWP_LANE_W-1:0] lane_idx_t;
    typedef logic [BWP_KEEP_W-1:0] keep_t;
    typedef logic [BWP_WORD_W-1:0] word_t;

endpackage

// File: rtl/byte_word_packer_word_out_slot.sv
// Single-entry ready/valid output register holding data, keep and last.
// Latency: 1 cycle from push to out_valid.
// Backpressure: contents held stable while out_valid && !out_ready; free is
//               high when empty or being drained this cycle.
//
// Ports: clk/reset (sync, active high); push_vld/push_data/push_keep/push_last
// load the slot (caller only pushes while free); free reports whether a push is
// allowed this cycle; out_* is the downstream ready/valid interface.
module word_out_slot #(
    parameter int WORD_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_vld,
    input  logic [WORD_W-1:0] push_data,
    input  logic [KEEP_W-1:0] push_keep,
    input  logic              push_last,
    output logic              free,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    input  logic              out_ready
);

    assign free = !out_valid || out_ready;

    // A push in the same cycle the held word drains replaces it directly,
    // which is what keeps back-to-back words bubble-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (push_vld) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
            out_keep  <= push_keep;
            out_last  <= push_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a non-stalling byte stream into little-endian words with lane keeps.
// Latency: 1 cycle from the word-completing byte (or flush) to out_valid.
// Backpressure: lanes 0..LANES-2 still fill while the output is blocked; the
//               last lane and pending flushes wait, excess bytes set overflow.
//
// Ports: clk/reset (sync, active high); in_valid/in_data byte input with
// advisory in_ready; flush requests emission of a partial word; out_valid/
// out_data/out_keep/out_last/out_ready word output; overflow is sticky.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int DATA_W = BWP_DATA_W,
    parameter int LANES  = BWP_LANES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [DATA_W*LANES-1:0] out_data,
    output logic [LANES-1:0]        out_keep,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    overflow
);

    localparam int WORD_W = DATA_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    // Fill count must represent LANES itself, one more than any lane index.
    localparam int CNT_W  = $clog2(LANES + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [WORD_W-1:0] acc, acc_d, acc_ins;
    logic [LANE_W-1:0] byte_cnt, byte_cnt_d;
    logic              flush_pending, flush_pending_d;
    logic              overflow_d;

    logic              slot_free;
    logic              accept;
    logic              word_full;
    logic              flush_req;
    logic [CNT_W-1:0]  fill;
    logic [LANES-1:0]  fill_keep;
    logic              push_vld;
    logic              push_last;

    assign in_ready  = !flush_pending && ((byte_cnt != LAST_LANE) || slot_free);
    assign accept    = in_valid && in_ready;
    assign word_full = accept && (byte_cnt == LAST_LANE);
    assign flush_req = flush || flush_pending;
    assign fill      = CNT_W'(byte_cnt) + CNT_W'(accept);

    // Accumulator with this cycle's byte merged in; unused lanes stay zero
    // because the accumulator is cleared every time a word leaves.
    always_comb begin
        acc_ins = acc;
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (byte_cnt == LANE_W'(i)) begin
                    acc_ins[i*DATA_W +: DATA_W] = in_data;
                end
            end
        end
    end

    // Keep covers the filled lanes; a full word naturally yields all ones.
    always_comb begin
        fill_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            fill_keep[i] = (CNT_W'(i) < fill);
        end
    end

    always_comb begin
        push_vld        = 1'b0;
        push_last       = 1'b0;
        acc_d           = acc_ins;
        byte_cnt_d      = byte_cnt + LANE_W'(accept);
        flush_pending_d = 1'b0;
        overflow_d      = overflow || (in_valid && !in_ready);

        if (word_full) begin
            // in_ready already guaranteed the slot is free for the last lane.
            push_vld   = 1'b1;
            push_last  = flush;
            acc_d      = '0;
            byte_cnt_d = '0;
        end else if (flush_req && (fill != '0)) begin
            if (slot_free) begin
                push_vld   = 1'b1;
                push_last  = 1'b1;
                acc_d      = '0;
                byte_cnt_d = '0;
            end else begin
                // Hold the flush until the slot drains; in_ready stays low so
                // the partial word cannot grow meanwhile.
                flush_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            byte_cnt      <= '0;
            flush_pending <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            acc           <= acc_d;
            byte_cnt      <= byte_cnt_d;
            flush_pending <= flush_pending_d;
            overflow      <= overflow_d;
        end
    end

    word_out_slot #(
        .WORD_W (WORD_W),
        .KEEP_W (LANES)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .push_vld  (push_vld),
        .push_data (acc_ins),
        .push_keep (fill_keep),
        .push_last (push_last),
        .free      (slot_free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer with hand-computed expected words.
module tb_byte_word_packer;
    import byte_word_packer_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    word_t       out_data;
    keep_t       out_keep;
    logic        out_last;
    logic        out_ready;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    byte_word_packer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One byte per call; consecutive calls give a gap-free stream.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  out_data,       d);
        check({tag, "_keep"},  32'(out_keep),  32'(k));
        check({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},    32'(out_valid), 32'd0);
        check({tag, "_data"},     out_data,       32'd0);
        check({tag, "_keep"},     32'(out_keep),  32'd0);
        check({tag, "_last"},     32'(out_last),  32'd0);
        check({tag, "_overflow"}, 32'(overflow),  32'd0);
        check({tag, "_in_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();
        check("rst_idle_valid", 32'(out_valid), 32'd0);

        // Continuous stream 01..08, downstream always ready.
        send(8'h01); send(8'h02); send(8'h03);
        check("t1_before_w0", 32'(out_valid), 32'd0);
        send(8'h04);
        check_word("t1_w0", 32'h04030201, 4'b1111, 1'b0);
        send(8'h05);
        check("t1_drained", 32'(out_valid), 32'd0);
        send(8'h06); send(8'h07); send(8'h08);
        check_word("t1_w1", 32'h08070605, 4'b1111, 1'b0);
        tick();
        check("t1_idle", 32'(out_valid), 32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Partial word closed by a flush.
        send(8'h07); send(8'h08); send(8'h09);
        check("t2_no_word", 32'(out_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_word("t2_w", 32'h00090807, 4'b0111, 1'b1);
        tick();
        check("t2_drained", 32'(out_valid), 32'd0);

        // Flush coinciding with the fourth byte: one full word, last set.
        send(8'h0A); send(8'h0B); send(8'h0C);
        flush = 1'b1;
        send(8'h0D);
        flush = 1'b0;
        check_word("t3_w", 32'h0D0C0B0A, 4'b1111, 1'b1);
        tick();
        check("t3_no_empty_a", 32'(out_valid), 32'd0);
        tick();
        check("t3_no_empty_b", 32'(out_valid), 32'd0);

        // Backpressure: lanes 0..2 still fill, lane 3 is dropped.
        out_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check_word("t4_held", 32'h04030201, 4'b1111, 1'b0);
        send(8'h05); send(8'h06); send(8'h07);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_no_ovf_yet", 32'(overflow), 32'd0);
        send(8'h08);
        check("t4_overflow", 32'(overflow), 32'd1);
        check_word("t4_still_held", 32'h04030201, 4'b1111, 1'b0);
        out_ready = 1'b1;
        tick();
        check("t4_drained", 32'(out_valid), 32'd0);
        check("t4_in_ready_back", 32'(in_ready), 32'd1);
        send(8'h44);
        check_word("t4_w1", 32'h44070605, 4'b1111, 1'b0);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        tick();

        // Reset mid-word discards the partial accumulator and clears overflow.
        send(8'h01); send(8'h02);
        reset = 1'b1;
        tick();
        check_reset_state("t5_rst");
        reset = 1'b0;
        send(8'h01); send(8'h02); send(8'h03);
        check("t5_no_stale_word", 32'(out_valid), 32'd0);
        send(8'h04);
        check_word("t5_w", 32'h04030201, 4'b1111, 1'b0);
        tick();

        // Flush while the slot is blocked waits, with in_ready held low.
        out_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check_word("t6_held", 32'h44332211, 4'b1111, 1'b0);
        send(8'hAA); send(8'hBB);
        check("t6_in_ready_pre", 32'(in_ready), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_in_ready_pend", 32'(in_ready), 32'd0);
        check("t6_held_data", out_data, 32'h44332211);
        tick();
        check("t6_in_ready_pend2", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check_word("t6_w", 32'h0000BBAA, 4'b0011, 1'b1);
        check("t6_in_ready_after", 32'(in_ready), 32'd1);
        tick();
        check("t6_drained", 32'(out_valid), 32'd0);

        // Reset while a word is held discards it.
        out_ready = 1'b0;
        send(8'h21); send(8'h22); send(8'h23); send(8'h24);
        check("t7_held_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("t7_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
